dso100fb_sequencer: RTL and testbench

Run-control sequencer for the DSO100 framebuffer pipeline, between the APB register block and the fetch engine / pixel FIFO / timing generator. It turns START/STOP command pulses into an ordered enable/prefill/drain sequence, reports STATE and STARTED/STOPPED event pulses back to the registers, and applies framebuffer address changes only at frame boundaries.

---
 rtl/dso100fb_sequencer.sv | 175 +++++++++++++++++
 tb/tb_dso100fb_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dso100fb_sequencer.sv
// Run-control sequencer for the DSO100 framebuffer pipeline: turns START/STOP
// pulses into ordered fetch/prefill/timing enables and a bounded drain.
module dso100fb_sequencer #(
   parameter int LEVEL_W       = 10,
   parameter int PREFILL_LEVEL = 256,
   parameter int DRAIN_TIMEOUT = 65535
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               START,
   input  logic               STOP,
   output logic               STARTED,
   output logic               STOPPED,
   output logic [1:0]         STATE,
   input  logic [31:0]        CFG_FB_BASE,
   input  logic [31:0]        CFG_FB_END,
   output logic [31:0]        FB_BASE,
   output logic [31:0]        FB_END,
   output logic               FETCH_ENABLE,
   output logic               FETCH_RESTART,
   input  logic               FETCH_IDLE,
   input  logic [LEVEL_W-1:0] FIFO_LEVEL,
   input  logic               FIFO_EMPTY,
   output logic               FIFO_FLUSH,
   output logic               TIMING_ENABLE,
   input  logic               FRAME_END,
   input  logic               PIXEL_REQ,
   output logic               UNDERRUN,
   output logic               DRAIN_TIMEOUT_ERR
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PREFILL = 2'd1;
   localparam logic [1:0] S_RUNNING = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   // Drain lasts at most DRAIN_TIMEOUT cycles: exit when the count reaches the last one.
   localparam logic [15:0]      DRAIN_LAST  = 16'(DRAIN_TIMEOUT - 1);
   localparam logic [LEVEL_W:0] PREFILL_THR = (LEVEL_W+1)'(PREFILL_LEVEL);

   logic [1:0]  r_state;
   logic        r_stop_pend;
   logic [15:0] r_drain_cnt;
   logic [31:0] r_fb_base;
   logic [31:0] r_fb_end;
   logic        r_started;
   logic        r_stopped;
   logic        r_fetch_en;
   logic        r_restart;
   logic        r_flush;
   logic        r_timing_en;
   logic        r_underrun;
   logic        r_tmo_err;

   logic [1:0]  w_state_nx;
   logic        w_pend_nx;
   logic [15:0] w_cnt_nx;
   logic        w_reload;
   logic        w_restart;
   logic        w_flush;
   logic        w_started;
   logic        w_stopped;
   logic        w_tmo;
   logic        w_underrun;
   logic        w_prefill_ok;

   assign w_prefill_ok = ({1'b0, FIFO_LEVEL} >= PREFILL_THR);
   assign w_underrun   = (r_state == S_RUNNING) && PIXEL_REQ && FIFO_EMPTY;

   always_comb begin
      w_state_nx = r_state;
      w_pend_nx  = r_stop_pend;
      w_cnt_nx   = r_drain_cnt;
      w_reload   = 1'b0;
      w_restart  = 1'b0;
      w_flush    = 1'b0;
      w_started  = 1'b0;
      w_stopped  = 1'b0;
      w_tmo      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_pend_nx = 1'b0;
            if (START && !STOP) begin
               w_state_nx = S_PREFILL;
               w_reload   = 1'b1;
               w_restart  = 1'b1;
               w_flush    = 1'b1;
            end
         end
         S_PREFILL: begin
            if (STOP) begin
               w_state_nx = S_DRAIN;
               w_cnt_nx   = '0;
               w_pend_nx  = 1'b0;
            end else if (w_prefill_ok) begin
               w_state_nx = S_RUNNING;
               w_started  = 1'b1;
            end
         end
         S_RUNNING: begin
            // A stop is only honoured at a frame boundary so the display never tears.
            if (FRAME_END) begin
               if (STOP || r_stop_pend) begin
                  w_state_nx = S_DRAIN;
                  w_cnt_nx   = '0;
                  w_pend_nx  = 1'b0;
               end else begin
                  w_reload  = 1'b1;
                  w_restart = 1'b1;
               end
            end else if (STOP) begin
               w_pend_nx = 1'b1;
            end
         end
         default: begin
            w_pend_nx = 1'b0;
            w_cnt_nx  = r_drain_cnt + 16'd1;
            if (FETCH_IDLE || (r_drain_cnt == DRAIN_LAST)) begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = '0;
               w_flush    = 1'b1;
               w_stopped  = 1'b1;
               w_tmo      = !FETCH_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= S_IDLE;
         r_stop_pend <= 1'b0;
         r_drain_cnt <= '0;
         r_fb_base   <= '0;
         r_fb_end    <= '0;
         r_started   <= 1'b0;
         r_stopped   <= 1'b0;
         r_fetch_en  <= 1'b0;
         r_restart   <= 1'b0;
         r_flush     <= 1'b0;
         r_timing_en <= 1'b0;
         r_underrun  <= 1'b0;
         r_tmo_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_stop_pend <= w_pend_nx;
         r_drain_cnt <= w_cnt_nx;
         r_started   <= w_started;
         r_stopped   <= w_stopped;
         r_fetch_en  <= (w_state_nx == S_PREFILL) || (w_state_nx == S_RUNNING);
         r_restart   <= w_restart;
         r_flush     <= w_flush;
         r_timing_en <= (w_state_nx == S_RUNNING);
         r_underrun  <= w_underrun;
         r_tmo_err   <= w_tmo;
         if (w_reload) begin
            r_fb_base <= CFG_FB_BASE;
            r_fb_end  <= CFG_FB_END;
         end
      end
   end

   assign STATE             = r_state;
   assign STARTED           = r_started;
   assign STOPPED           = r_stopped;
   assign FB_BASE           = r_fb_base;
   assign FB_END            = r_fb_end;
   assign FETCH_ENABLE      = r_fetch_en;
   assign FETCH_RESTART     = r_restart;
   assign FIFO_FLUSH        = r_flush;
   assign TIMING_ENABLE     = r_timing_en;
   assign UNDERRUN          = r_underrun;
   assign DRAIN_TIMEOUT_ERR = r_tmo_err;

endmodule

// File: tb/tb_dso100fb_sequencer.sv
// Bench for dso100fb_sequencer: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_dso100fb_sequencer;

   localparam int LEVEL_W       = 10;
   localparam int PREFILL_LEVEL = 256;
   localparam int DRAIN_TIMEOUT = 16;

   logic               CLK;
   logic               RST_N;
   logic               START;
   logic               STOP;
   logic               STARTED;
   logic               STOPPED;
   logic [1:0]         STATE;
   logic [31:0]        CFG_FB_BASE;
   logic [31:0]        CFG_FB_END;
   logic [31:0]        FB_BASE;
   logic [31:0]        FB_END;
   logic               FETCH_ENABLE;
   logic               FETCH_RESTART;
   logic               FETCH_IDLE;
   logic [LEVEL_W-1:0] FIFO_LEVEL;
   logic               FIFO_EMPTY;
   logic               FIFO_FLUSH;
   logic               TIMING_ENABLE;
   logic               FRAME_END;
   logic               PIXEL_REQ;
   logic               UNDERRUN;
   logic               DRAIN_TIMEOUT_ERR;

   dso100fb_sequencer #(
      .LEVEL_W(LEVEL_W), .PREFILL_LEVEL(PREFILL_LEVEL), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP),
      .STARTED(STARTED), .STOPPED(STOPPED), .STATE(STATE),
      .CFG_FB_BASE(CFG_FB_BASE), .CFG_FB_END(CFG_FB_END),
      .FB_BASE(FB_BASE), .FB_END(FB_END),
      .FETCH_ENABLE(FETCH_ENABLE), .FETCH_RESTART(FETCH_RESTART), .FETCH_IDLE(FETCH_IDLE),
      .FIFO_LEVEL(FIFO_LEVEL), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_FLUSH(FIFO_FLUSH),
      .TIMING_ENABLE(TIMING_ENABLE), .FRAME_END(FRAME_END), .PIXEL_REQ(PIXEL_REQ),
      .UNDERRUN(UNDERRUN), .DRAIN_TIMEOUT_ERR(DRAIN_TIMEOUT_ERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Behavioural model: phase numbers are the visible STATE codes.
   int          m_phase = 0;
   bit          m_stop_req = 0;
   int          m_drain_cycles = 0;
   logic [31:0] m_base = '0;
   logic [31:0] m_end  = '0;
   bit m_started, m_stopped, m_restart, m_flush, m_under, m_err, m_drain_go;

   always begin
      @(posedge CLK);
      {m_started, m_stopped, m_restart, m_flush, m_under, m_err, m_drain_go} = '0;
      if (!RST_N) begin
         m_phase = 0; m_stop_req = 0; m_drain_cycles = 0; m_base = '0; m_end = '0;
      end else begin
         m_under = (m_phase == 2) && PIXEL_REQ && FIFO_EMPTY;
         case (m_phase)
            0: begin
               m_stop_req = 0;
               if (START && !STOP) begin
                  m_phase = 1; m_base = CFG_FB_BASE; m_end = CFG_FB_END;
                  m_restart = 1; m_flush = 1;
               end
            end
            1: begin
               if (STOP) m_drain_go = 1;
               else if (FIFO_LEVEL >= PREFILL_LEVEL) begin m_phase = 2; m_started = 1; end
            end
            2: begin
               if (FRAME_END) begin
                  if (STOP || m_stop_req) m_drain_go = 1;
                  else begin m_base = CFG_FB_BASE; m_end = CFG_FB_END; m_restart = 1; end
               end else if (STOP) m_stop_req = 1;
            end
            default: begin
               m_drain_cycles++;
               if (FETCH_IDLE || m_drain_cycles == DRAIN_TIMEOUT) begin
                  m_err = !FETCH_IDLE;
                  m_phase = 0; m_stopped = 1; m_flush = 1;
               end
            end
         endcase
         if (m_drain_go) begin m_phase = 3; m_drain_cycles = 0; m_stop_req = 0; end
      end
      #1;
      chk("model STATE", {30'd0, STATE}, m_phase);
      chk("model flags {started,stopped,fetch_en,restart,flush,timing_en,underrun,tmo}",
          {24'd0, STARTED, STOPPED, FETCH_ENABLE, FETCH_RESTART, FIFO_FLUSH, TIMING_ENABLE, UNDERRUN, DRAIN_TIMEOUT_ERR},
          {24'd0, m_started, m_stopped, bit'(RST_N && (m_phase == 1 || m_phase == 2)), m_restart, m_flush,
           bit'(RST_N && m_phase == 2), m_under, m_err});
      chk("model FB_BASE", FB_BASE, m_base);
      chk("model FB_END", FB_END, m_end);
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   int n_run;
   int n_drain;
   int timing_seen;

   initial begin
      RST_N = 0; START = 0; STOP = 0; CFG_FB_BASE = '0; CFG_FB_END = '0; FETCH_IDLE = 0;
      FIFO_LEVEL = '0; FIFO_EMPTY = 0; FRAME_END = 0; PIXEL_REQ = 0;
      repeat (3) tick();
      chk("reset STATE", {30'd0, STATE}, 0);
      chk("reset FETCH_ENABLE", {31'd0, FETCH_ENABLE}, 0);
      chk("reset FB_BASE", FB_BASE, 0);
      RST_N = 1;
      tick();

      STOP = 1; tick(); STOP = 0;
      chk("idle STOP STATE", {30'd0, STATE}, 0);
      chk("idle STOP STOPPED", {31'd0, STOPPED}, 0);

      // Start and prefill ramp
      CFG_FB_BASE = 32'h2000_0000; CFG_FB_END = 32'h2010_0000;
      START = 1; tick(); START = 0;
      chk("start STATE", {30'd0, STATE}, 1);
      chk("start FETCH_RESTART", {31'd0, FETCH_RESTART}, 1);
      chk("start FIFO_FLUSH", {31'd0, FIFO_FLUSH}, 1);
      chk("start FETCH_ENABLE", {31'd0, FETCH_ENABLE}, 1);
      chk("start FB_BASE", FB_BASE, 32'h2000_0000);
      chk("start FB_END", FB_END, 32'h2010_0000);
      for (int l = 1; l <= 300; l++) begin
         FIFO_LEVEL = l[LEVEL_W-1:0];
         tick();
         if (l == 1) chk("restart one cycle", {31'd0, FETCH_RESTART}, 0);
         if (l == 255) chk("prefill at 255", {30'd0, STATE}, 1);
         if (l == 256) begin
            chk("STARTED at 256", {31'd0, STARTED}, 1);
            chk("running STATE", {30'd0, STATE}, 2);
            chk("running TIMING_ENABLE", {31'd0, TIMING_ENABLE}, 1);
         end
         if (l == 257) chk("STARTED one cycle", {31'd0, STARTED}, 0);
      end

      // Frame-boundary reload
      CFG_FB_BASE = 32'h1000_0000;
      repeat (10) tick();
      chk("mid-frame FB_BASE held", FB_BASE, 32'h2000_0000);
      FRAME_END = 1; tick(); FRAME_END = 0;
      chk("reload FB_BASE", FB_BASE, 32'h1000_0000);
      chk("reload FETCH_RESTART", {31'd0, FETCH_RESTART}, 1);

      // Underrun
      PIXEL_REQ = 1; FIFO_EMPTY = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("underrun pulse", {31'd0, UNDERRUN}, 1);
      end
      PIXEL_REQ = 0; tick(); FIFO_EMPTY = 0;
      chk("underrun cleared", {31'd0, UNDERRUN}, 0);

      // Graceful stop: waits for the frame end, then drains
      STOP = 1; tick(); STOP = 0;
      chk("stop pending STATE", {30'd0, STATE}, 2);
      n_run = 0;
      for (int i = 0; i < 499; i++) begin
         tick();
         if (STATE == 2) n_run++;
      end
      chk("stop pending cycles in RUNNING", n_run, 499);
      CFG_FB_BASE = 32'h3000_0000;
      FRAME_END = 1; tick(); FRAME_END = 0;
      chk("drain STATE", {30'd0, STATE}, 3);
      chk("drain no restart", {31'd0, FETCH_RESTART}, 0);
      chk("drain TIMING_ENABLE", {31'd0, TIMING_ENABLE}, 0);
      chk("drain no reload", FB_BASE, 32'h1000_0000);
      repeat (9) tick();
      chk("drain waits", {30'd0, STATE}, 3);
      FETCH_IDLE = 1; tick(); FETCH_IDLE = 0;
      chk("stopped pulse", {31'd0, STOPPED}, 1);
      chk("stopped flush", {31'd0, FIFO_FLUSH}, 1);
      chk("stopped STATE", {30'd0, STATE}, 0);
      chk("graceful no timeout", {31'd0, DRAIN_TIMEOUT_ERR}, 0);

      // Abort in prefill, then drain timeout
      FIFO_LEVEL = '0; START = 1; tick(); START = 0;
      FIFO_LEVEL = 10'd100; tick();
      STOP = 1; tick(); STOP = 0;
      chk("abort STATE", {30'd0, STATE}, 3);
      chk("abort no STARTED", {31'd0, STARTED}, 0);
      n_drain = 0; timing_seen = 0;
      while (STATE == 3 && n_drain < 100) begin
         tick();
         n_drain++;
         if (TIMING_ENABLE) timing_seen++;
      end
      chk("timeout drain cycles", n_drain, DRAIN_TIMEOUT);
      chk("timeout ERR", {31'd0, DRAIN_TIMEOUT_ERR}, 1);
      chk("timeout STOPPED", {31'd0, STOPPED}, 1);
      chk("abort timing never on", timing_seen, 0);

      // START+STOP together
      START = 1; STOP = 1; tick(); START = 0; STOP = 0;
      chk("idle START+STOP STATE", {30'd0, STATE}, 0);
      chk("idle START+STOP flush", {31'd0, FIFO_FLUSH}, 0);
      START = 1; tick();
      STOP = 1; tick(); START = 0; STOP = 0;
      chk("prefill START+STOP STATE", {30'd0, STATE}, 3);
      FETCH_IDLE = 1; tick(); FETCH_IDLE = 0;

      // STOP and FRAME_END on the same edge
      START = 1; tick(); START = 0;
      FIFO_LEVEL = 10'd300; tick();
      chk("run again STATE", {30'd0, STATE}, 2);
      STOP = 1; FRAME_END = 1; tick(); STOP = 0; FRAME_END = 0;
      chk("stop+frame_end STATE", {30'd0, STATE}, 3);
      chk("stop+frame_end no restart", {31'd0, FETCH_RESTART}, 0);
      FETCH_IDLE = 1; tick(); FETCH_IDLE = 0;

      // Asynchronous reset while running
      START = 1; tick(); START = 0; tick();
      chk("pre-reset STATE", {30'd0, STATE}, 2);
      RST_N = 0; #1;
      chk("async reset FETCH_ENABLE", {31'd0, FETCH_ENABLE}, 0);
      chk("async reset TIMING_ENABLE", {31'd0, TIMING_ENABLE}, 0);
      chk("async reset STATE", {30'd0, STATE}, 0);
      chk("async reset FB_BASE", FB_BASE, 0);
      tick(); tick();
      chk("reset no STOPPED", {31'd0, STOPPED}, 0);
      RST_N = 1; tick();

      // Randomized traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         START       = ($urandom_range(0, 15) == 0);
         STOP        = ($urandom_range(0, 24) == 0);
         FRAME_END   = ($urandom_range(0, 29) == 0);
         FETCH_IDLE  = ($urandom_range(0, 9) == 0);
         FIFO_LEVEL  = LEVEL_W'($urandom_range(0, 1023));
         FIFO_EMPTY  = 1'($urandom_range(0, 1));
         PIXEL_REQ   = 1'($urandom_range(0, 1));
         CFG_FB_BASE = $urandom;
         CFG_FB_END  = $urandom;
         tick();
      end

      START = 0; STOP = 0; FRAME_END = 0; PIXEL_REQ = 0;
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
